// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer between core stores and dcache port 0.
// Entry layout and the byte-merge helper used by coalescing.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 30;
    localparam int SB_DATA_W = 32;
    localparam int SB_WM_W   = SB_DATA_W / 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_WM_W-1:0]   wm;
    } SBEntry;

    function automatic logic [SB_DATA_W-1:0] sb_merge(
        input logic [SB_DATA_W-1:0] old_d,
        input logic [SB_DATA_W-1:0] new_d,
        input logic [SB_WM_W-1:0]   wm
    );
        logic [SB_DATA_W-1:0] r;
        r = old_d;
        for (int b = 0; b < SB_WM_W; b++) begin
            if (wm[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core store port, dcache write port and load-forward lookup of the store buffer.
// master = core/cache side environment, slave = the buffer itself.
interface store_buffer_if #(
    parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W,
    parameter int DATA_W = store_buffer_pkg::SB_DATA_W
);
    localparam int WM_W = DATA_W / 8;

    logic              IN_valid;
    logic [ADDR_W-1:0] IN_addr;
    logic [DATA_W-1:0] IN_data;
    logic [WM_W-1:0]   IN_wm;
    logic              OUT_ready;

    logic              OUT_DC_ce;
    logic              OUT_DC_we;
    logic [WM_W-1:0]   OUT_DC_wm;
    logic [ADDR_W-1:0] OUT_DC_addr;
    logic [DATA_W-1:0] OUT_DC_data;
    logic              IN_DC_busy;

    logic [ADDR_W-1:0] IN_fwdAddr;
    logic [WM_W-1:0]   OUT_fwdMask;
    logic [DATA_W-1:0] OUT_fwdData;

    logic              IN_flush;
    logic              OUT_empty;

    modport master (
        output IN_valid, IN_addr, IN_data, IN_wm,
        output IN_DC_busy, IN_fwdAddr, IN_flush,
        input  OUT_ready, OUT_DC_ce, OUT_DC_we, OUT_DC_wm,
        input  OUT_DC_addr, OUT_DC_data,
        input  OUT_fwdMask, OUT_fwdData, OUT_empty
    );

    modport slave (
        input  IN_valid, IN_addr, IN_data, IN_wm,
        input  IN_DC_busy, IN_fwdAddr, IN_flush,
        output OUT_ready, OUT_DC_ce, OUT_DC_we, OUT_DC_wm,
        output OUT_DC_addr, OUT_DC_data,
        output OUT_fwdMask, OUT_fwdData, OUT_empty
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// Per-byte store-to-load forwarding: youngest resident entry matching the
// lookup address wins each byte; uncovered bytes read as zero.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  SBEntry               entries [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [PTR_W-1:0]     tail,
    input  logic [SB_ADDR_W-1:0] fwd_addr,
    output logic [SB_WM_W-1:0]   fwd_mask,
    output logic [SB_DATA_W-1:0] fwd_data
);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] age_idx [DEPTH];
    SBEntry           aged    [DEPTH];
    logic [DEPTH-1:0] hit;

    assign count = tail - head;

    // slot g holds the g-th oldest resident entry
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_idx[g] = head[IDX_W-1:0] + IDX_W'(g);
        assign aged[g]    = entries[age_idx[g]];
        assign hit[g]     = (PTR_W'(g) < count) &&
                            (aged[g].addr == fwd_addr);
    end

    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                for (int b = 0; b < SB_WM_W; b++) begin
                    if (aged[i].wm[b]) begin
                        fwd_mask[b]       = 1'b1;
                        fwd_data[b*8 +: 8] = aged[i].data[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: decouples core stores from dcache write port 0, merging
// stores to the youngest word and forwarding resident bytes to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int WM_W  = DATA_W / 8;

    SBEntry           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_m1;
    logic [PTR_W-1:0] count;

    logic             empty;
    logic             full;
    logic             coal_hit;
    logic             accept;
    logic             alloc;
    logic             merge;
    logic             deq;

    SBEntry            head_e;
    SBEntry            young_e;
    SBEntry            in_e;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_data;
    logic [WM_W-1:0]   dc_wm;

    assign count   = tail - head;
    assign tail_m1 = tail - PTR_W'(1);
    assign empty   = (head == tail);
    assign full    = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                     (head[IDX_W] != tail[IDX_W]);

    assign head_e  = mem[head[IDX_W-1:0]];
    assign young_e = mem[tail_m1[IDX_W-1:0]];
    assign in_e    = '{addr: sb.IN_addr, data: sb.IN_data, wm: sb.IN_wm};

    // the head may be mid-write, so only a younger entry may absorb a store
    assign coal_hit = !sb.IN_flush &&
                      (count > PTR_W'(1)) &&
                      (young_e.addr == sb.IN_addr);

    assign sb.OUT_ready = !sb.IN_flush && (!full || coal_hit);

    assign accept = sb.IN_valid && sb.OUT_ready;
    assign merge  = accept && coal_hit;
    assign alloc  = accept && !coal_hit;
    assign deq    = !empty && !sb.IN_DC_busy;

    assign dc_addr = empty ? '0 : head_e.addr;
    assign dc_data = empty ? '0 : head_e.data;
    assign dc_wm   = empty ? '0 : head_e.wm;

    assign sb.OUT_DC_ce   = empty;
    assign sb.OUT_DC_we   = empty;
    assign sb.OUT_DC_addr = dc_addr;
    assign sb.OUT_DC_data = dc_data;
    assign sb.OUT_DC_wm   = dc_wm;
    assign sb.OUT_empty   = empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (deq)   head <= head + PTR_W'(1);
            if (alloc) tail <= tail + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (alloc) begin
                mem[tail[IDX_W-1:0]] <= in_e;
            end else if (merge) begin
                mem[tail_m1[IDX_W-1:0]].data <=
                    sb_merge(young_e.data, sb.IN_data, sb.IN_wm);
                mem[tail_m1[IDX_W-1:0]].wm <= young_e.wm | sb.IN_wm;
            end
        end
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries  (mem),
        .head     (head),
        .tail     (tail),
        .fwd_addr (sb.IN_fwdAddr),
        .fwd_mask (sb.OUT_fwdMask),
        .fwd_data (sb.OUT_fwdData)
    );

endmodule
